write_back_stage: RTL

Parametrised successor to the combinational write-back mux. The MEM/WB pipeline register and write-back select logic are merged into one clocked stage.
- Selects among memory data, ALU result, PC+4 (link) and upper-immediate sources.
- Performs load byte/half extraction with sign or zero extension.
- Handles stall and flush, suppresses writes to register 0, and counts retired instructions.
- Sits between the data-memory stage and the register file write port; its outputs also feed the forwarding unit.

---
 rtl/write_back_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register merged with write-back source selection and load
// extraction; also counts instructions leaving the stage.
module write_back_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned OFF_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_pc_plus4,
  input  logic [DATA_W-1:0]     in_imm_upper,
  input  logic [1:0]            in_wb_sel,
  input  logic [1:0]            in_load_size,
  input  logic                  in_load_unsigned,
  input  logic [OFF_W-1:0]      in_byte_off,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_write_data,
  output logic [CNT_W-1:0]      retired_count
);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;
  localparam logic [1:0] SEL_IMM = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  logic                  r_valid;
  logic [DATA_W-1:0]     r_mem_data;
  logic [DATA_W-1:0]     r_alu_result;
  logic [DATA_W-1:0]     r_pc_plus4;
  logic [DATA_W-1:0]     r_imm_upper;
  logic [1:0]            r_wb_sel;
  logic [1:0]            r_load_size;
  logic                  r_load_unsigned;
  logic [OFF_W-1:0]      r_byte_off;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic [CNT_W-1:0]      r_retired;

  logic                  w_leave;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_data;

  // MEM/WB register: flush loads a bubble and wins over stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid         <= 1'b0;
      r_mem_data      <= '0;
      r_alu_result    <= '0;
      r_pc_plus4      <= '0;
      r_imm_upper     <= '0;
      r_wb_sel        <= '0;
      r_load_size     <= '0;
      r_load_unsigned <= 1'b0;
      r_byte_off      <= '0;
      r_rd            <= '0;
      r_reg_write     <= 1'b0;
    end else if (flush) begin
      r_valid         <= 1'b0;
      r_mem_data      <= '0;
      r_alu_result    <= '0;
      r_pc_plus4      <= '0;
      r_imm_upper     <= '0;
      r_wb_sel        <= '0;
      r_load_size     <= '0;
      r_load_unsigned <= 1'b0;
      r_byte_off      <= '0;
      r_rd            <= '0;
      r_reg_write     <= 1'b0;
    end else if (!stall) begin
      r_valid         <= in_valid;
      r_mem_data      <= in_mem_data;
      r_alu_result    <= in_alu_result;
      r_pc_plus4      <= in_pc_plus4;
      r_imm_upper     <= in_imm_upper;
      r_wb_sel        <= in_wb_sel;
      r_load_size     <= in_load_size;
      r_load_unsigned <= in_load_unsigned;
      r_byte_off      <= in_byte_off;
      r_rd            <= in_rd;
      r_reg_write     <= in_reg_write;
    end
  end

  // The held instruction leaves whenever the stage is not stalled, flush or not
  assign w_leave = r_valid & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_leave) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Little-endian lane pick; half-word ignores the low offset bit
  assign w_byte = r_mem_data[{r_byte_off, 3'b000} +: 8];
  assign w_half = r_mem_data[{r_byte_off[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    w_load = r_mem_data;
    case (r_load_size)
      SIZE_BYTE: w_load = {{(DATA_W-8){w_byte[7] & ~r_load_unsigned}}, w_byte};
      SIZE_HALF: w_load = {{(DATA_W-16){w_half[15] & ~r_load_unsigned}}, w_half};
      default:   w_load = r_mem_data;
    endcase
  end

  always_comb begin
    w_data = '0;
    if (r_valid) begin
      case (r_wb_sel)
        SEL_ALU: w_data = r_alu_result;
        SEL_MEM: w_data = w_load;
        SEL_PC4: w_data = r_pc_plus4;
        SEL_IMM: w_data = r_imm_upper;
        default: w_data = '0;
      endcase
    end
  end

  assign wb_valid      = r_valid;
  assign wb_reg_write  = r_valid & r_reg_write & (r_rd != '0);
  assign wb_rd         = r_rd;
  assign wb_write_data = w_data;
  assign retired_count = r_retired;

endmodule
